// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle PC-update sequencer: PC source select, PC/EPC write enables, retire count
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        stall,
  input  logic [2:0]  kind,
  input  logic        zero,
  input  logic        overflow,
  output logic [2:0]  pc_source,
  output logic        pc_write,
  output logic        epc_write,
  output logic [1:0]  cause,
  output logic        busy,
  output logic        done,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    RESOLVE = 3'd3,
    EXC     = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [2:0]  kind_q;
  logic [1:0]  cause_q, cause_n;
  logic [31:0] count_q;
  logic        hold;
  logic        pw_raw, ew_raw, done_raw;

  // stall only freezes an instruction in flight; IDLE still accepts fetch_req
  assign hold = stall && (state != IDLE);

  always_comb begin
    state_n   = state;
    cause_n   = cause_q;
    pc_source = 3'd0;
    pw_raw    = 1'b0;
    ew_raw    = 1'b0;
    done_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_req) begin
          state_n = FETCH;
          cause_n = 2'd0;
        end
      end
      FETCH: begin
        pw_raw  = 1'b1;
        state_n = DECODE;
      end
      DECODE: state_n = RESOLVE;
      RESOLVE: begin
        // invalid opcode outranks overflow
        if (kind_q[2:1] == 2'b11) begin
          cause_n = 2'd1;
          state_n = EXC;
        end else if (overflow) begin
          cause_n = 2'd2;
          state_n = EXC;
        end else begin
          state_n = DONE;
          case (kind_q)
            3'd1: begin pc_source = 3'd1; pw_raw = zero;  end
            3'd2: begin pc_source = 3'd1; pw_raw = !zero; end
            3'd3: begin pc_source = 3'd2; pw_raw = 1'b1;  end
            3'd4: begin pc_source = 3'd3; pw_raw = 1'b1;  end
            default: ;
          endcase
        end
      end
      EXC: begin
        pc_source = 3'd4;
        pw_raw    = 1'b1;
        ew_raw    = 1'b1;
        state_n   = DONE;
      end
      DONE: begin
        done_raw = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (hold) begin
      state_n = state;
      cause_n = cause_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      kind_q  <= 3'd0;
      cause_q <= 2'd0;
      count_q <= 32'd0;
    end else begin
      state   <= state_n;
      cause_q <= cause_n;
      if (state == DECODE && !hold)
        kind_q <= kind;
      if (state == DONE && !hold)
        count_q <= count_q + 32'd1;
    end
  end

  assign pc_write    = pw_raw && !hold && !reset;
  assign epc_write   = ew_raw && !hold && !reset;
  assign done        = done_raw && !hold && !reset;
  assign busy        = (state != IDLE);
  assign cause       = cause_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, fetch_req, stall, zero, overflow;
  logic [2:0]  kind;
  logic [2:0]  pc_source;
  logic        pc_write, epc_write, busy, done;
  logic [1:0]  cause;
  logic [31:0] instr_count;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .stall(stall),
    .kind(kind), .zero(zero), .overflow(overflow),
    .pc_source(pc_source), .pc_write(pc_write), .epc_write(epc_write),
    .cause(cause), .busy(busy), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  src;
    logic        pw;
    logic        ew;
    logic        bsy;
    logic        dn;
    logic        chk_cause;
    logic [1:0]  cs;
    logic        chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_cnt;
  logic [1:0]  m_cause;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] src, input logic pw, input logic ew,
                              input logic bsy, input logic dn, input logic chk_cause,
                              input logic [1:0] cs, input logic chk_cnt, input logic [31:0] cnt);
    exp_t e;
    e.src = src; e.pw = pw; e.ew = ew; e.bsy = bsy; e.dn = dn;
    e.chk_cause = chk_cause; e.cs = cs; e.chk_cnt = chk_cnt; e.cnt = cnt;
    return e;
  endfunction

  // Called 1 time unit after a rising edge; drives one cycle, scores it at the falling edge.
  task automatic cycle(input logic fr, input logic st, input exp_t e_in);
    exp_t e;
    fetch_req = fr;
    stall     = st;
    exp_q.push_back(e_in);
    @(negedge clk);
    e = exp_q.pop_front();
    check("pc_source", pc_source, e.src);
    check("pc_write", pc_write, e.pw);
    check("epc_write", epc_write, e.ew);
    check("busy", busy, e.bsy);
    check("done", done, e.dn);
    if (e.chk_cause) check("cause", cause, e.cs);
    if (e.chk_cnt) check("instr_count", instr_count, e.cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [2:0] k, input logic z, input logic ov,
                           input int nstall, input logic noisy);
    logic       exc;
    logic [2:0] src;
    logic       pw;
    logic [1:0] c;
    kind = k; zero = z; overflow = ov;
    exc = (k >= 3'd6) || ov;
    c   = (k >= 3'd6) ? 2'd1 : (ov ? 2'd2 : 2'd0);
    src = 3'd0;
    pw  = 1'b0;
    if (!exc) begin
      case (k)
        3'd1: begin src = 3'd1; pw = z;    end
        3'd2: begin src = 3'd1; pw = !z;   end
        3'd3: begin src = 3'd2; pw = 1'b1; end
        3'd4: begin src = 3'd3; pw = 1'b1; end
        default: ;
      endcase
    end
    cycle(1'b1, 1'b0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_cause, 1'b1, m_cnt));
    cycle(noisy, 1'b0, mk(3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0));
    m_cause = 2'd0;
    cycle(noisy, 1'b0, mk(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0));
    for (int i = 0; i < nstall; i++)
      cycle(noisy, 1'b1, mk(src, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0));
    cycle(noisy, 1'b0, mk(src, pw, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'd0));
    if (exc) begin
      m_cause = c;
      cycle(noisy, 1'b0, mk(3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, c, 1'b0, 32'd0));
    end
    cycle(noisy, 1'b0, mk(3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, m_cause, 1'b1, m_cnt));
    m_cnt = m_cnt + 32'd1;
    cycle(1'b0, 1'b0, mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_cause, 1'b1, m_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fetch_req = 1'b0; stall = 1'b0;
    kind = 3'd0; zero = 1'b0; overflow = 1'b0;
    m_cnt = 32'd0; m_cause = 2'd0;
    @(posedge clk);
    @(negedge clk);
    check("rst_pc_source", pc_source, 32'd0);
    check("rst_pc_write", pc_write, 32'd0);
    check("rst_epc_write", epc_write, 32'd0);
    check("rst_cause", cause, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_count", instr_count, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(3'd0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(3'd1, 1'b1, 1'b0, 0, 1'b0);
    run_instr(3'd2, 1'b1, 1'b0, 0, 1'b0);
    run_instr(3'd3, 1'b0, 1'b0, 0, 1'b0);
    run_instr(3'd4, 1'b0, 1'b0, 0, 1'b0);
    run_instr(3'd7, 1'b0, 1'b1, 0, 1'b0);
    run_instr(3'd0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(3'd5, 1'b1, 1'b1, 0, 1'b0);
    run_instr(3'd6, 1'b0, 1'b0, 1, 1'b0);
    run_instr(3'd1, 1'b0, 1'b0, 0, 1'b0);
    run_instr(3'd2, 1'b0, 1'b0, 0, 1'b1);
    run_instr(3'd3, 1'b0, 1'b0, 3, 1'b1);
    for (int i = 0; i < 8; i++)
      run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    // reset asserted while in DECODE
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rstdec_pc_write", pc_write, 32'd0);
    check("rstdec_busy", busy, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstdec_idle_busy", busy, 32'd0);
    check("rstdec_idle_pw", pc_write, 32'd0);
    check("rstdec_count", instr_count, 32'd0);
    m_cnt = 32'd0;
    m_cause = 2'd0;

    // reset asserted while in FETCH suppresses the fetch write
    @(posedge clk); #1;
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rstfetch_pc_write", pc_write, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstfetch_busy", busy, 32'd0);

    // counter wrap
    force dut.count_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.count_q;
    m_cnt = 32'hFFFF_FFFF;
    run_instr(3'd0, 1'b0, 1'b0, 0, 1'b0);
    check("wrap_count", instr_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
